stage3_execution_mdu: RTL and testbench

// - Parametrised next-generation execute stage: operand forwarding from NUM_FWD sources, single-cycle ALU,

---
 rtl/stage3_execution_mdu_pkg.sv | 32 +++
 rtl/stage3_execution_mdu_mdu_iter.sv | 141 ++++++++++++++
 rtl/stage3_execution_mdu.sv | 131 +++++++++++++
 tb/tb_stage3_execution_mdu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stage3_execution_mdu_pkg.sv
// Shared execute-stage types: ALU/MDU op codes, branch kinds, MDU FSM states.
// Imported by the execute stage and its iterative multiply/divide unit.
package tcore_param;

    localparam int TCORE_XLEN = 32;
    localparam int MDU_CNT_W = $clog2(TCORE_XLEN);
    localparam logic DIV0_Q = 1'b1;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [3:0] {
        PC_NONE, PC_BEQ, PC_BNE, PC_BLT, PC_BGE,
        PC_BLTU, PC_BGEU, PC_JAL, PC_JALR
    } pc_sel_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;

    function automatic logic is_mul_op(alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_mdu_op(alu_op_e op);
        return is_mul_op(op) ||
            (op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
    endfunction

endpackage

// File: rtl/stage3_execution_mdu_mdu_iter.sv
// Radix-2 shift-add multiplier / restoring divider with result register.
// TCORE_FAST_MUL_EN: multiplies finish in one cycle through a full multiplier.
module mdu_iter
    import tcore_param::*;
#(
    parameter int XLEN = TCORE_XLEN,
    parameter int CW = MDU_CNT_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            start_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   opd;
    alu_op_e           op_q;
    logic              neg_q;
    logic              mul_q;

    logic            sgn_a;
    logic            sgn_b;
    logic            neg_in;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] ma;
    logic [XLEN-1:0] mb;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rp;
    logic [XLEN-1:0] diff;
    logic            ge;

    // acc holds {hi, lo} of the product or {remainder, quotient}
    function automatic logic [XLEN-1:0] fin(
        alu_op_e op, logic neg, logic [2*XLEN-1:0] v
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        p = neg ? -v : v;
        q = neg ? -v[XLEN-1:0] : v[XLEN-1:0];
        r = neg ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
        if (op == ALU_MUL) return p[XLEN-1:0];
        if (is_mul_op(op)) return p[2*XLEN-1:XLEN];
        if (op inside {ALU_DIV, ALU_DIVU}) return q;
        return r;
    endfunction

    always_comb begin
        sgn_a = a_i[XLEN-1] &&
            (op_i inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        sgn_b = b_i[XLEN-1] &&
            (op_i inside {ALU_MULH, ALU_DIV, ALU_REM});
        ma = sgn_a ? -a_i : a_i;
        mb = sgn_b ? -b_i : b_i;
        neg_in = (op_i == ALU_REM) ? sgn_a : (sgn_a ^ sgn_b);
        div0 = !is_mul_op(op_i) && (b_i == '0);
        ovf = (op_i inside {ALU_DIV, ALU_REM}) &&
            (a_i == MIN) && (&b_i);
        sum = {1'b0, acc[2*XLEN-1:XLEN]} +
            (acc[0] ? {1'b0, opd} : '0);
        rp = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge = rp >= {1'b0, opd};
        diff = rp[XLEN-1:0] - opd;
        if (mul_q)
            acc_nxt = {sum, acc[XLEN-1:1]};
        else
            acc_nxt = {ge ? diff : rp[XLEN-1:0], acc[XLEN-2:0], ge};
    end

    assign stall_o = !flush_i &&
        (((state == IDLE) && start_i) || (state == BUSY));
    assign done_o = !flush_i && (state == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opd      <= '0;
            op_q     <= ALU_ADD;
            neg_q    <= 1'b0;
            mul_q    <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start_i) begin
                    op_q  <= op_i;
                    neg_q <= neg_in;
                    mul_q <= is_mul_op(op_i);
                    cnt   <= '0;
                    if (div0) begin
                        result_o <= (op_i inside {ALU_DIV, ALU_DIVU}) ?
                            {XLEN{DIV0_Q}} : a_i;
                        state <= DONE;
                    end else if (ovf) begin
                        result_o <= (op_i == ALU_DIV) ? MIN : '0;
                        state <= DONE;
                    end
`ifdef TCORE_FAST_MUL_EN
                    else if (is_mul_op(op_i)) begin
                        result_o <= fin(op_i, neg_in,
                            {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb});
                        state <= DONE;
                    end
`endif
                    else begin
                        acc   <= {{XLEN{1'b0}}, ma};
                        opd   <= mb;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        result_o <= fin(op_q, neg_q, acc_nxt);
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/stage3_execution_mdu.sv
// Execute stage: forwarding, ALU, branch resolution, stalling RV32M unit.
// TCORE_FAST_MUL_EN selects the single-cycle multiplier inside mdu_iter.
module stage3_execution_mdu
    import tcore_param::*;
#(
    parameter int XLEN = TCORE_XLEN,
    parameter int NUM_FWD = 2,
    localparam int FWD_W = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    ex_valid_i,
    input  logic [FWD_W-1:0]        fwd_a_i,
    input  logic [FWD_W-1:0]        fwd_b_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
    input  logic [XLEN-1:0]         r1_data_i,
    input  logic [XLEN-1:0]         r2_data_i,
    input  logic [1:0]              alu_in1_sel_i,
    input  logic                    alu_in2_sel_i,
    input  logic                    is_comp_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [XLEN-1:0]         imm_i,
    input  pc_sel_e                 pc_sel_i,
    input  alu_op_e                 alu_ctrl_i,
    output logic [XLEN-1:0]         write_data_o,
    output logic [XLEN-1:0]         pc_target_o,
    output logic                    pc_sel_o,
    output logic [XLEN-1:0]         alu_result_o,
    output logic                    ex_stall_o
);

    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mdu_res;
    logic [XLEN-1:0] jalr_sum;
    logic [SW-1:0]   sh;
    logic            mdu_done;
    logic            eq;
    logic            lt;
    logic            ltu;

    always_comb begin
        op_a = r1_data_i;
        op_b = r2_data_i;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwd_a_i == FWD_W'(k))
                op_a = fwd_data_i[(k-1)*XLEN +: XLEN];
            if (fwd_b_i == FWD_W'(k))
                op_b = fwd_data_i[(k-1)*XLEN +: XLEN];
        end
    end

    always_comb begin
        unique case (alu_in1_sel_i)
            2'b00: in1 = op_a;
            2'b01: in1 = pc_i + (is_comp_i ? XLEN'(2) : XLEN'(4));
            2'b10: in1 = pc_i;
            default: in1 = '0;
        endcase
        in2 = alu_in2_sel_i ? imm_i : op_b;
    end

    assign sh = in2[SW-1:0];

    always_comb begin
        unique case (alu_ctrl_i)
            ALU_ADD:  alu_res = in1 + in2;
            ALU_SUB:  alu_res = in1 - in2;
            ALU_SLL:  alu_res = in1 << sh;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                 $signed(in1) < $signed(in2)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, in1 < in2};
            ALU_XOR:  alu_res = in1 ^ in2;
            ALU_SRL:  alu_res = in1 >> sh;
            ALU_SRA:  alu_res = $signed(in1) >>> sh;
            ALU_OR:   alu_res = in1 | in2;
            ALU_AND:  alu_res = in1 & in2;
            ALU_LUI:  alu_res = in2;
            default:  alu_res = '0;
        endcase
    end

    assign eq  = op_a == op_b;
    assign lt  = $signed(op_a) < $signed(op_b);
    assign ltu = op_a < op_b;

    always_comb begin
        unique case (pc_sel_i)
            PC_BEQ:  pc_sel_o = eq;
            PC_BNE:  pc_sel_o = !eq;
            PC_BLT:  pc_sel_o = lt;
            PC_BGE:  pc_sel_o = !lt;
            PC_BLTU: pc_sel_o = ltu;
            PC_BGEU: pc_sel_o = !ltu;
            PC_JAL,
            PC_JALR: pc_sel_o = 1'b1;
            default: pc_sel_o = 1'b0;
        endcase
        pc_sel_o = pc_sel_o && ex_valid_i;
    end

    assign jalr_sum = op_a + imm_i;
    assign pc_target_o = (pc_sel_i == PC_JALR) ?
        {jalr_sum[XLEN-1:1], 1'b0} : pc_i + imm_i;
    assign write_data_o = op_b;

    mdu_iter #(
        .XLEN (XLEN),
        .CW   (SW)
    ) u_mdu (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .start_i  (ex_valid_i && is_mdu_op(alu_ctrl_i)),
        .op_i     (alu_ctrl_i),
        .a_i      (op_a),
        .b_i      (op_b),
        .stall_o  (ex_stall_o),
        .done_o   (mdu_done),
        .result_o (mdu_res)
    );

    assign alu_result_o = mdu_done ? mdu_res : alu_res;

endmodule

// File: tb/tb_stage3_execution_mdu.sv
// Directed self-checking bench for stage3_execution_mdu.
// Multiply stall expectation follows TCORE_FAST_MUL_EN.
module tb_stage3_execution_mdu;
    import tcore_param::*;

`ifdef TCORE_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif

    logic        clk = 0;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] fwd0;
    logic [31:0] fwd1;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [1:0]  sel1;
    logic        sel2;
    logic        is_comp;
    logic [31:0] pc;
    logic [31:0] imm;
    pc_sel_e     pc_sel_in;
    alu_op_e     alu_ctrl;
    logic [31:0] wdata;
    logic [31:0] target;
    logic        redirect;
    logic [31:0] res;
    logic        stall;

    int checks = 0;
    int errors = 0;
    int n;
    int seen;

    always #5 clk = ~clk;

    stage3_execution_mdu dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .ex_valid_i    (ex_valid),
        .fwd_a_i       (fwd_a),
        .fwd_b_i       (fwd_b),
        .fwd_data_i    ({fwd1, fwd0}),
        .r1_data_i     (r1),
        .r2_data_i     (r2),
        .alu_in1_sel_i (sel1),
        .alu_in2_sel_i (sel2),
        .is_comp_i     (is_comp),
        .pc_i          (pc),
        .imm_i         (imm),
        .pc_sel_i      (pc_sel_in),
        .alu_ctrl_i    (alu_ctrl),
        .write_data_o  (wdata),
        .pc_target_o   (target),
        .pc_sel_o      (redirect),
        .alu_result_o  (res),
        .ex_stall_o    (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // leaves the DUT in its result cycle; n = stall cycles seen
    task automatic run_mdu(input alu_op_e op, input logic [31:0] a,
                           input logic [31:0] b, output int cyc);
        @(posedge clk); #1;
        ex_valid = 1; alu_ctrl = op; r1 = a; r2 = b;
        fwd_a = 0; fwd_b = 0; sel1 = 0; sel2 = 0;
        pc_sel_in = PC_NONE; #1;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
            r1 = 32'hDEAD_BEEF; r2 = 32'h0;
        end
    endtask

    task automatic idle_cycle();
        ex_valid = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 0; flush = 0; ex_valid = 1;
        fwd_a = 0; fwd_b = 0; fwd0 = 0; fwd1 = 0;
        r1 = 3; r2 = 4; sel1 = 0; sel2 = 0; is_comp = 0;
        pc = 0; imm = 0; pc_sel_in = PC_NONE; alu_ctrl = ALU_ADD;
        #12;
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_res", res, 7);
        @(posedge clk); #1;
        rst_n = 1;

        fwd_a = 1; fwd0 = 5; r1 = 99; r2 = 7; #1;
        chk("add_fwd", res, 12);
        chk("add_stall", {31'b0, stall}, 0);
        fwd_a = 0; fwd_b = 2; r1 = 50; fwd1 = 8; alu_ctrl = ALU_SUB; #1;
        chk("sub_fwd_b", res, 42);
        chk("store_data", wdata, 8);
        fwd_b = 0;
        r1 = 32'hFFFF_FFFF; r2 = 1; alu_ctrl = ALU_SLT; #1;
        chk("slt", res, 1);
        r1 = 32'h8000_0000; r2 = 4; alu_ctrl = ALU_SRA; #1;
        chk("sra", res, 32'hF800_0000);
        sel1 = 2'b01; sel2 = 1; is_comp = 1; pc = 32'h100; imm = 0;
        alu_ctrl = ALU_ADD; #1;
        chk("link_c", res, 32'h102);
        sel1 = 0; sel2 = 0; is_comp = 0;

        r1 = 32'hFFFF_FFFF; r2 = 32'hFFFF_FFFF; pc_sel_in = PC_BGE; #1;
        chk("bge_eq", {31'b0, redirect}, 1);
        r1 = 1; pc_sel_in = PC_BLTU; #1;
        chk("bltu", {31'b0, redirect}, 1);
        r2 = 2; pc_sel_in = PC_BEQ; pc = 32'h200; imm = 32'hFFFF_FFF8; #1;
        chk("beq_nt", {31'b0, redirect}, 0);
        chk("br_target", target, 32'h1F8);
        r1 = 32'h1001; imm = 2; pc_sel_in = PC_JALR; #1;
        chk("jalr_target", target, 32'h1002);
        chk("jalr_taken", {31'b0, redirect}, 1);
        pc_sel_in = PC_NONE; imm = 0; pc = 0;

        run_mdu(ALU_MULHU, 32'hFFFF_FFFF, 2, n);
        chk("mulhu_stall", n, MUL_STALL);
        chk("mulhu_res", res, 1);
        run_mdu(ALU_MUL, 32'hFFFF_FFFF, 2, n);
        chk("mul_stall", n, MUL_STALL);
        chk("mul_res", res, 32'hFFFF_FFFE);
        run_mdu(ALU_MULH, 32'hFFFF_FFFD, 5, n);
        chk("mulh_res", res, 32'hFFFF_FFFF);
        run_mdu(ALU_MUL, 3, 4, n);
        chk("mul34_stall", n, MUL_STALL);
        chk("mul34_res", res, 12);
        run_mdu(ALU_DIV, 32'hFFFF_FFF9, 2, n);
        chk("div_stall", n, 33);
        chk("div_res", res, 32'hFFFF_FFFD);
        run_mdu(ALU_REM, 32'hFFFF_FFF9, 2, n);
        chk("rem_res", res, 32'hFFFF_FFFF);
        run_mdu(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("ovf_stall", n, 1);
        chk("ovf_q", res, 32'h8000_0000);
        run_mdu(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("ovf_r", res, 0);
        run_mdu(ALU_DIVU, 100, 0, n);
        chk("div0_stall", n, 1);
        chk("div0_q", res, 32'hFFFF_FFFF);
        run_mdu(ALU_REMU, 100, 0, n);
        chk("div0_r_stall", n, 1);
        chk("div0_r", res, 100);
        idle_cycle();
        chk("done_to_idle", {31'b0, stall}, 0);

        ex_valid = 1; alu_ctrl = ALU_DIV; r1 = 32'hFFFF_FFF9; r2 = 2; #1;
        chk("acc_stall", {31'b0, stall}, 1);
        repeat (10) begin @(posedge clk); #1; end
        chk("busy_stall", {31'b0, stall}, 1);
        flush = 1; #1;
        chk("flush_stall", {31'b0, stall}, 0);
        @(posedge clk); #1;
        flush = 0; alu_ctrl = ALU_ADD; r1 = 1; r2 = 2; #1;
        chk("flush_idle_stall", {31'b0, stall}, 0);
        chk("flush_idle_res", res, 3);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (stall || res !== 32'd3) seen++;
        end
        chk("flush_no_result", seen, 0);

        run_mdu(ALU_DIVU, 100, 7, n);
        idle_cycle();
        ex_valid = 1; alu_ctrl = ALU_DIVU; r1 = 100; r2 = 7;
        repeat (6) begin @(posedge clk); #1; end
        rst_n = 0; ex_valid = 0; alu_ctrl = ALU_ADD; r1 = 1; r2 = 1; #1;
        chk("mid_rst_stall", {31'b0, stall}, 0);
        chk("mid_rst_res", res, 2);
        @(posedge clk); #1;
        rst_n = 1;
        run_mdu(ALU_DIVU, 100, 7, n);
        chk("divu_stall", n, 33);
        chk("divu_res", res, 14);
        run_mdu(ALU_REMU, 100, 7, n);
        chk("remu_res", res, 2);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
